// File: rtl/fpu_op_sequencer.sv
// FPU operation sequencer: dispatches an operation to the add/sub unit or the
// multiplier, watches for completion with a timeout, strobes the result register
// and holds completion until the host acknowledges.
module fpu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic             ack,
    output logic             arith_start,
    output logic [3:0]       arith_op,
    input  logic             arith_done,
    output logic             mul_start,
    output logic             mul_square,
    input  logic             mul_done,
    output logic             result_latch,
    output logic             result_sel,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        op_add    = 4'd0,
        op_sub    = 4'd1,
        op_mul    = 4'd2,
        op_square = 4'd3,
        op_div    = 4'd4,
        op_sqrt   = 4'd5,
        op_sin    = 4'd6,
        op_cos    = 4'd7,
        op_exp    = 4'd8
    } e_fpu_operation;

    typedef enum logic [3:0] {
        main_idle_st     = 4'd0,
        main_wait_st     = 4'd1,
        main_mul_wait_st = 4'd2,
        main_finish_st   = 4'd3,
        main_wait_ack_st = 4'd4
    } e_main_state;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    e_main_state      state_q;
    logic [CNT_W-1:0] watchdog;
    logic             unit_done;

    assign state = state_q;

    // Completion from whichever unit the current wait state belongs to.
    always_comb begin
        unit_done = 1'b0;
        if (state_q == main_wait_st) begin
            unit_done = arith_done;
        end else if (state_q == main_mul_wait_st) begin
            unit_done = mul_done;
        end
    end

    // Main controller: state, watchdog and all registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= main_idle_st;
            watchdog     <= '0;
            arith_start  <= 1'b0;
            arith_op     <= op_add;
            mul_start    <= 1'b0;
            mul_square   <= 1'b0;
            result_latch <= 1'b0;
            result_sel   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            cycle_count  <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            arith_start  <= 1'b0;
            mul_start    <= 1'b0;
            result_latch <= 1'b0;

            case (state_q)
                main_idle_st: begin
                    if (start) begin
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        watchdog <= CNT_ONE;
                        if (operation == op_add || operation == op_sub) begin
                            arith_op    <= operation;
                            result_sel  <= 1'b0;
                            arith_start <= 1'b1;
                            state_q     <= main_wait_st;
                        end else if (operation == op_mul || operation == op_square) begin
                            result_sel  <= 1'b1;
                            mul_square  <= (operation == op_square);
                            mul_start   <= 1'b1;
                            state_q     <= main_mul_wait_st;
                        end else begin
                            // Unsupported code: no unit is started and no time is charged.
                            error       <= 1'b1;
                            watchdog    <= '0;
                            cycle_count <= '0;
                            state_q     <= main_finish_st;
                        end
                    end
                end

                main_wait_st, main_mul_wait_st: begin
                    // Completion takes priority over a coincident timeout.
                    if (unit_done) begin
                        cycle_count  <= watchdog;
                        result_latch <= 1'b1;
                        state_q      <= main_finish_st;
                    end else if (watchdog == TIMEOUT_VAL) begin
                        cycle_count <= watchdog;
                        error       <= 1'b1;
                        state_q     <= main_finish_st;
                    end else begin
                        watchdog <= watchdog + CNT_ONE;
                    end
                end

                main_finish_st: begin
                    done    <= 1'b1;
                    state_q <= main_wait_ack_st;
                end

                main_wait_ack_st: begin
                    if (ack) begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= main_idle_st;
                    end
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= main_idle_st;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: a default instance and a short-timeout
// instance, per-operation expectations queued at start and checked at done.
module tb_fpu_op_sequencer;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_SQR = 4'd3;
    localparam logic [3:0] OP_SIN = 4'd6;
    localparam logic [3:0] OP_UND = 4'd15;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  operation = 4'd0;
    logic        ack = 1'b0;
    logic        arith_done = 1'b0;
    logic        mul_done = 1'b0;
    logic        use_t = 1'b0;

    logic        d_as, d_ms, d_sq, d_rl, d_sel, d_busy, d_done, d_err;
    logic [3:0]  d_op, d_state;
    logic [15:0] d_cc;
    logic        t_as, t_ms, t_sq, t_rl, t_sel, t_busy, t_done, t_err;
    logic [3:0]  t_op, t_state;
    logic [15:0] t_cc;

    logic        o_as, o_ms, o_sq, o_rl, o_sel, o_busy, o_done, o_err;
    logic [3:0]  o_op, o_state;
    logic [15:0] o_cc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sel;
        int sq;
        int op;
        int cc;
        int err;
        int lat;
        int ast;
        int mst;
        int st1;
    } exp_t;

    exp_t sb[$];
    int   m_sel[2];
    int   m_sq[2];
    int   m_op[2];

    always #5 clk = ~clk;

    fpu_op_sequencer dut (
        .clk(clk), .arst(arst), .start(start & ~use_t), .operation(operation), .ack(ack & ~use_t),
        .arith_start(d_as), .arith_op(d_op), .arith_done(arith_done & ~use_t),
        .mul_start(d_ms), .mul_square(d_sq), .mul_done(mul_done & ~use_t),
        .result_latch(d_rl), .result_sel(d_sel), .busy(d_busy), .done(d_done),
        .error(d_err), .cycle_count(d_cc), .state(d_state)
    );

    fpu_op_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut_t (
        .clk(clk), .arst(arst), .start(start & use_t), .operation(operation), .ack(ack & use_t),
        .arith_start(t_as), .arith_op(t_op), .arith_done(arith_done & use_t),
        .mul_start(t_ms), .mul_square(t_sq), .mul_done(mul_done & use_t),
        .result_latch(t_rl), .result_sel(t_sel), .busy(t_busy), .done(t_done),
        .error(t_err), .cycle_count(t_cc), .state(t_state)
    );

    assign o_as    = use_t ? t_as    : d_as;
    assign o_ms    = use_t ? t_ms    : d_ms;
    assign o_sq    = use_t ? t_sq    : d_sq;
    assign o_rl    = use_t ? t_rl    : d_rl;
    assign o_sel   = use_t ? t_sel   : d_sel;
    assign o_busy  = use_t ? t_busy  : d_busy;
    assign o_done  = use_t ? t_done  : d_done;
    assign o_err   = use_t ? t_err   : d_err;
    assign o_op    = use_t ? t_op    : d_op;
    assign o_state = use_t ? t_state : d_state;
    assign o_cc    = use_t ? t_cc    : d_cc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then stable and new inputs apply to this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({o_as, o_ms, o_sq, o_rl, o_sel, o_busy, o_done, o_err, o_op, o_state, o_cc}), 0);
    endtask

    // One operation: model the expected outcome, drive it, observe until done, acknowledge.
    // done_cyc is the wait-cycle index (1 = cycle of the start pulse) carrying unit done; 0 = never.
    task automatic run_op(input bit t, input logic [3:0] op, input int done_cyc,
                          input bit ack_hold, input bit busy_starts, input bit noise);
        exp_t e;
        exp_t g;
        int   tmo;
        int   k;
        int   n_as;
        int   n_ms;
        int   n_rl;
        int   k_as;
        int   k_rl;
        bit   is_ar;
        bit   is_mu;

        tmo   = t ? 8 : 256;
        is_ar = (op == OP_ADD || op == OP_SUB);
        is_mu = (op == OP_MUL || op == OP_SQR);
        if (is_ar) begin
            m_sel[t] = 0;
            m_op[t]  = int'(op);
        end else if (is_mu) begin
            m_sel[t] = 1;
            m_sq[t]  = (op == OP_SQR) ? 1 : 0;
        end
        e.sel = m_sel[t];
        e.sq  = m_sq[t];
        e.op  = m_op[t];
        e.ast = is_ar ? 1 : 0;
        e.mst = is_mu ? 1 : 0;
        e.st1 = is_ar ? 1 : (is_mu ? 2 : 3);
        if (!is_ar && !is_mu) begin
            e.cc = 0; e.err = 1; e.lat = 0;
        end else if (done_cyc != 0 && done_cyc <= tmo) begin
            e.cc = done_cyc; e.err = 0; e.lat = 1;
        end else begin
            e.cc = tmo; e.err = 1; e.lat = 0;
        end
        sb.push_back(e);

        use_t     = t;
        operation = op;
        ack       = ack_hold;
        start     = 1'b1;
        tick();
        start = 1'b0;
        k = 1; n_as = 0; n_ms = 0; n_rl = 0; k_as = 0; k_rl = 0;
        check("state_first_cycle", 32'(o_state), e.st1);
        check("busy_first_cycle", 32'(o_busy), 1);
        while (!o_done && k < 400) begin
            if (o_as) begin n_as++; k_as = k; end
            if (o_ms) begin n_ms++; k_as = k; end
            if (o_rl) begin n_rl++; k_rl = k; end
            arith_done = is_ar ? (k == done_cyc) : (is_mu && noise);
            mul_done   = is_mu ? (k == done_cyc) : (is_ar && noise);
            if (busy_starts) begin
                start     = (k % 2) == 0;
                operation = OP_MUL;
            end
            tick();
            k++;
        end
        arith_done = 1'b0;
        mul_done   = 1'b0;
        start      = 1'b0;
        if (!o_done) begin
            check("done_timeout", 0, 1);
        end else begin
            g = sb.pop_front();
            check("result_sel", 32'(o_sel), g.sel);
            check("mul_square", 32'(o_sq), g.sq);
            check("arith_op", 32'(o_op), g.op);
            check("cycle_count", 32'(o_cc), g.cc);
            check("error", 32'(o_err), g.err);
            check("latch_count", n_rl, g.lat);
            check("arith_start_count", n_as, g.ast);
            check("mul_start_count", n_ms, g.mst);
            if (g.ast + g.mst > 0) check("start_pulse_cycle", k_as, 1);
            if (g.lat > 0) check("done_after_latch", k, k_rl + 1);
            check("state_wait_ack", 32'(o_state), 4);
        end
        if (!ack_hold) begin
            tick();
            tick();
            check("done_held", 32'(o_done), 1);
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end else begin
            tick();
            ack = 1'b0;
        end
        check("idle_after_ack", 32'({o_busy, o_done, o_state}), 0);
    endtask

    initial begin
        int n_rl;
        m_sel = '{0, 0};
        m_sq  = '{0, 0};
        m_op  = '{0, 0};

        #12;
        use_t = 1'b0;
        #1;
        check_all_zero("reset_d");
        use_t = 1'b1;
        #1;
        check_all_zero("reset_t");
        tick();
        arst = 1'b0;
        tick();

        // add with done three cycles after the start pulse
        run_op(0, OP_ADD, 4, 0, 0, 0);
        // square, arith_done noise during the wait
        run_op(0, OP_SQR, 24, 0, 0, 1);
        // unsupported codes set error; next accepted op clears it
        run_op(0, OP_SIN, 0, 0, 0, 0);
        run_op(0, OP_SUB, 2, 0, 0, 0);
        run_op(0, OP_UND, 0, 0, 0, 0);
        // short timeout: no done, then done exactly on the timeout cycle
        run_op(1, OP_MUL, 0, 0, 0, 0);
        run_op(1, OP_MUL, 8, 0, 0, 0);
        run_op(1, OP_MUL, 7, 0, 0, 0);
        // starts while busy, ack held, back-to-back with zero-latency units
        run_op(0, OP_ADD, 5, 1, 1, 0);
        run_op(0, OP_MUL, 1, 1, 0, 0);
        run_op(0, OP_SUB, 1, 1, 0, 0);

        // reset during a multiply wait, then a late mul_done
        use_t     = 1'b0;
        operation = OP_MUL;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("state_before_reset", 32'(o_state), 2);
        arst = 1'b1;
        #1;
        check_all_zero("reset_mid_op");
        tick();
        arst     = 1'b0;
        mul_done = 1'b1;
        n_rl     = 0;
        repeat (3) begin
            tick();
            if (o_rl) n_rl++;
        end
        mul_done = 1'b0;
        check("late_done_no_latch", n_rl, 0);
        check_all_zero("idle_after_late_done");
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
